de_burst_writer: RTL and testbench

//  Parametrised writer for decrypted RC4 messages. Copies a MSG_LEN-word result vector into
//  on-chip RAM starting at BASE_ADDR, one word per write slot.

---
 rtl/de_pkg.sv | 22 ++
 rtl/de_wait_counter.sv | 29 ++
 rtl/de_burst_writer.sv | 170 +++++++++++++++++
 tb/tb_de_burst_writer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/de_pkg.sv
// Shared types and helpers for the decrypted-message burst writer.
// Holds the writer FSM encoding and the plaintext character qualifier.
package de_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_GAP,
      ST_READ,
      ST_RWAIT,
      ST_DONE
   } de_wr_state_t;

   localparam logic [7:0] CH_LO = 8'h61;
   localparam logic [7:0] CH_HI = 8'h7A;
   localparam logic [7:0] CH_SP = 8'h20;

   function automatic logic is_plain_char(input logic [7:0] c);
      return ((c >= CH_LO) && (c <= CH_HI)) || (c == CH_SP);
   endfunction

endpackage

// File: rtl/de_wait_counter.sv
// Loadable down-counter timing the write gap and read-back wait.
// Stops at zero; the zero flag tells the FSM the wait has elapsed.
module de_wait_counter
#(
   parameter int W = 4
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/de_burst_writer.sv
// Copies a decrypted RC4 message into result RAM, one word per slot,
// with optional read-back verification and plaintext qualification.
module de_burst_writer
   import de_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int MSG_LEN    = 32,
   parameter int ADDR_W     = 8,
   parameter int BASE_ADDR  = 0,
   parameter int WR_GAP     = 0,
   parameter int VERIFY     = 0,
   parameter int RD_LAT     = 1,
   parameter int CHAR_CHECK = 1
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      abort,
   input  logic [MSG_LEN*DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0]         mem_q,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   output logic                      mem_wren,
   output logic                      busy,
   output logic                      done,
   output logic                      msg_valid,
   output logic                      verify_err
);

   localparam int IW      = $clog2(MSG_LEN + 1);
   localparam int CNT_MAX = (WR_GAP > RD_LAT) ? WR_GAP : RD_LAT;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [IW-1:0] LAST   = IW'(MSG_LEN - 1);
   localparam logic [CW-1:0] GAP_LD = CW'((WR_GAP > 0) ? WR_GAP - 1 : 0);
   localparam logic [CW-1:0] RD_LD  = CW'(RD_LAT - 1);

   de_wr_state_t state, state_nxt;
   logic [IW-1:0] idx, idx_nxt;
   logic mv_nxt, ve_nxt, adv;
   logic cnt_load, cnt_dec, cnt_zero;
   logic [CW-1:0] cnt_val;
   logic wren_nxt, busy_nxt, done_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] wdata_nxt, cur_word;

   // Padded to a power of two so any index value selects a defined word
   logic [DATA_W-1:0] words [2**IW];

   for (genvar i = 0; i < 2**IW; i++) begin : g_word
      if (i < MSG_LEN) begin : g_live
         assign words[i] = data_in[i*DATA_W +: DATA_W];
      end else begin : g_pad
         assign words[i] = '0;
      end
   end

   assign cur_word = words[idx];

   de_wait_counter #(
      .W        (CW)
   ) u_wait (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         idx        <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wren   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         msg_valid  <= 1'b0;
         verify_err <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         mem_addr   <= addr_nxt;
         mem_wdata  <= wdata_nxt;
         mem_wren   <= wren_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         msg_valid  <= mv_nxt;
         verify_err <= ve_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      mv_nxt    = msg_valid;
      ve_nxt    = verify_err;
      cnt_load  = 1'b0;
      cnt_val   = '0;
      cnt_dec   = 1'b0;
      adv       = 1'b0;
      if ((state != ST_IDLE) && abort) begin
         state_nxt = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  state_nxt = ST_WRITE;
                  idx_nxt   = '0;
                  mv_nxt    = 1'b1;
                  ve_nxt    = 1'b0;
               end
            end
            ST_WRITE: begin
               if ((CHAR_CHECK != 0) && !is_plain_char(8'(cur_word)))
                  mv_nxt = 1'b0;
               if (WR_GAP > 0) begin
                  state_nxt = ST_GAP;
                  cnt_load  = 1'b1;
                  cnt_val   = GAP_LD;
               end else if (VERIFY != 0) begin
                  state_nxt = ST_READ;
               end else begin
                  adv = 1'b1;
               end
            end
            ST_GAP: begin
               if (!cnt_zero) cnt_dec = 1'b1;
               else if (VERIFY != 0) state_nxt = ST_READ;
               else adv = 1'b1;
            end
            ST_READ: begin
               state_nxt = ST_RWAIT;
               cnt_load  = 1'b1;
               cnt_val   = RD_LD;
            end
            ST_RWAIT: begin
               if (!cnt_zero) begin
                  cnt_dec = 1'b1;
               end else begin
                  if (mem_q != cur_word) ve_nxt = 1'b1;
                  adv = 1'b1;
               end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
         if (adv) begin
            if (idx == LAST) begin
               state_nxt = ST_DONE;
            end else begin
               idx_nxt   = idx + 1'b1;
               state_nxt = ST_WRITE;
            end
         end
      end
   end

   // Outputs are decoded from the next state so they appear registered
   always_comb begin
      wren_nxt  = (state_nxt == ST_WRITE);
      busy_nxt  = state_nxt inside {ST_WRITE, ST_GAP, ST_READ, ST_RWAIT};
      done_nxt  = (state_nxt == ST_DONE);
      addr_nxt  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_nxt);
      wdata_nxt = words[idx_nxt];
   end

endmodule

// File: tb/tb_de_burst_writer.sv
// Directed bench for de_burst_writer across four parameter sets.
// Expected timing and data are hand-derived from the message contents.
module tb_de_burst_writer;

   logic clk = 1'b0;
   logic rst_n;
   logic [3:0] st, ab;
   logic [255:0] din0, din1, din2;
   logic [7:0] din3;
   logic [7:0] q2;
   logic corrupt;
   logic [7:0] ram2 [256];

   wire [3:0] wren, busy, done, mv, ve;
   wire [3:0][7:0] addr, wdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   de_burst_writer u0 (
      .clk(clk), .reset(rst_n), .start(st[0]), .abort(ab[0]),
      .data_in(din0), .mem_q(8'h00), .mem_addr(addr[0]),
      .mem_wdata(wdata[0]), .mem_wren(wren[0]), .busy(busy[0]),
      .done(done[0]), .msg_valid(mv[0]), .verify_err(ve[0])
   );

   de_burst_writer #(.WR_GAP(2), .BASE_ADDR('hE0)) u1 (
      .clk(clk), .reset(rst_n), .start(st[1]), .abort(ab[1]),
      .data_in(din1), .mem_q(8'h00), .mem_addr(addr[1]),
      .mem_wdata(wdata[1]), .mem_wren(wren[1]), .busy(busy[1]),
      .done(done[1]), .msg_valid(mv[1]), .verify_err(ve[1])
   );

   de_burst_writer #(.VERIFY(1), .RD_LAT(1)) u2 (
      .clk(clk), .reset(rst_n), .start(st[2]), .abort(ab[2]),
      .data_in(din2), .mem_q(q2), .mem_addr(addr[2]),
      .mem_wdata(wdata[2]), .mem_wren(wren[2]), .busy(busy[2]),
      .done(done[2]), .msg_valid(mv[2]), .verify_err(ve[2])
   );

   de_burst_writer #(.MSG_LEN(1), .BASE_ADDR(5)) u3 (
      .clk(clk), .reset(rst_n), .start(st[3]), .abort(ab[3]),
      .data_in(din3), .mem_q(8'h00), .mem_addr(addr[3]),
      .mem_wdata(wdata[3]), .mem_wren(wren[3]), .busy(busy[3]),
      .done(done[3]), .msg_valid(mv[3]), .verify_err(ve[3])
   );

   // One-cycle-latency RAM; word 5 reads back corrupted when enabled
   always @(posedge clk) begin
      if (wren[2]) ram2[addr[2]] <= wdata[2];
      q2 <= (corrupt && addr[2] == 8'd5) ? ~ram2[addr[2]] : ram2[addr[2]];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run(input int u, input int base, input int n,
                      input int per, input int ab_c,
                      input logic [255:0] d, input int max_c,
                      output int nwr, output int aerr,
                      output int dcyc, output int vcyc);
      nwr = 0; aerr = 0; dcyc = -1; vcyc = -1;
      @(negedge clk); st[u] = 1'b1;
      @(negedge clk); st[u] = 1'b0;
      for (int c = 1; c <= max_c; c++) begin
         if (wren[u]) begin
            if (nwr >= n || c != 1 + per*nwr ||
                addr[u] != 8'(base + nwr) ||
                wdata[u] != d[(nwr%32)*8 +: 8]) aerr++;
            nwr++;
         end
         if (done[u] && dcyc < 0) dcyc = c;
         if (ve[u] && vcyc < 0) vcyc = c;
         ab[u] = (c == ab_c);
         @(negedge clk);
      end
      ab[u] = 1'b0;
   endtask

   string s = "hello world this is a secret msg";
   logic [255:0] msg, bad;
   logic [7:0] cv [6] = '{8'h7A, 8'h20, 8'h60, 8'h7B, 8'h61, 8'h40};
   logic ce [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   int nwr, aerr, dcyc, vcyc, cnt;

   initial begin
      rst_n = 1'b0; st = '0; ab = '0; corrupt = 1'b0;
      for (int i = 0; i < 32; i++) msg[i*8 +: 8] = s[i];
      din0 = msg; din1 = msg; din2 = msg; din3 = 8'h61;
      repeat (2) @(negedge clk);
      chk("rst_out", 32'({wren[0], busy[0], done[0], mv[0], ve[0],
                          addr[0], wdata[0]}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run(0, 0, 32, 1, 0, msg, 36, nwr, aerr, dcyc, vcyc);
      chk("t1_nwr", nwr, 32);
      chk("t1_bus", aerr, 0);
      chk("t1_done", dcyc, 33);
      chk("t1_mv", 32'(mv[0]), 1);
      chk("t1_busy", 32'(busy[0]), 0);

      run(1, 'hE0, 32, 3, 0, msg, 100, nwr, aerr, dcyc, vcyc);
      chk("t2_nwr", nwr, 32);
      chk("t2_bus", aerr, 0);
      chk("t2_done", dcyc, 97);

      corrupt = 1'b1;
      run(2, 0, 32, 3, 0, msg, 100, nwr, aerr, dcyc, vcyc);
      chk("t3_nwr", nwr, 32);
      chk("t3_bus", aerr, 0);
      chk("t3_done", dcyc, 97);
      chk("t3_verr_cyc", vcyc, 19);
      chk("t3_verr", 32'(ve[2]), 1);
      corrupt = 1'b0;
      run(2, 0, 32, 3, 0, msg, 100, nwr, aerr, dcyc, vcyc);
      chk("t3_clean_cyc", vcyc, -1);
      chk("t3_clean_verr", 32'(ve[2]), 0);

      bad = msg;
      bad[7*8 +: 8] = 8'h41;
      din0 = bad;
      run(0, 0, 32, 1, 0, bad, 36, nwr, aerr, dcyc, vcyc);
      chk("t4_bus", aerr, 0);
      chk("t4_mv_bad", 32'(mv[0]), 0);
      din0 = msg;
      run(0, 0, 32, 1, 0, msg, 36, nwr, aerr, dcyc, vcyc);
      chk("t4_mv_ok", 32'(mv[0]), 1);
      chk("t4_verr", 32'(ve[0]), 0);

      run(0, 0, 32, 1, 11, msg, 20, nwr, aerr, dcyc, vcyc);
      chk("t5_nwr", nwr, 11);
      chk("t5_bus", aerr, 0);
      chk("t5_nodone", dcyc, -1);
      chk("t5_busy", 32'(busy[0]), 0);
      run(0, 0, 32, 1, 0, msg, 36, nwr, aerr, dcyc, vcyc);
      chk("t5_re_nwr", nwr, 32);
      chk("t5_re_bus", aerr, 0);
      chk("t5_re_done", dcyc, 33);

      @(negedge clk); st[0] = 1'b1;
      @(negedge clk); st[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("t6_busy_pre", 32'(busy[0]), 1);
      #2 rst_n = 1'b0;
      #1 chk("t6_rst_out", 32'({wren[0], busy[0], done[0], mv[0], ve[0],
                                addr[0], wdata[0]}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; st[0] = 1'b1; ab[0] = 1'b1;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (busy[0] || wren[0] || done[0]) cnt++;
      end
      st[0] = 1'b0; ab[0] = 1'b0;
      chk("t6_abort_wins", cnt, 0);

      for (int i = 0; i < 6; i++) begin
         din3 = cv[i];
         run(3, 5, 1, 1, 0, {248'd0, cv[i]}, 5, nwr, aerr, dcyc, vcyc);
         chk($sformatf("t7_nwr_%0d", i), nwr, 1);
         chk($sformatf("t7_bus_%0d", i), aerr, 0);
         chk($sformatf("t7_done_%0d", i), dcyc, 2);
         chk($sformatf("t7_mv_%0h", cv[i]), 32'(mv[3]), 32'(ce[i]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
